// File: rtl/led_pattern_ctrl_if.sv
// rtl/led_pattern_ctrl_if.sv - board-pin bundle between the switches/LEDs and the front-panel controller
interface led_pattern_ctrl_if;
  logic SW1;
  logic SW2;
  logic SW3;
  logic SW4;
  logic LED1;
  logic LED2;
  logic LED3;
  logic LED4;
  logic LED5;

  modport master (
    output SW1, SW2, SW3, SW4,
    input  LED1, LED2, LED3, LED4, LED5
  );

  modport slave (
    input  SW1, SW2, SW3, SW4,
    output LED1, LED2, LED3, LED4, LED5
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - debounced front-panel switches driving a tick-stepped LED pattern engine
module led_pattern_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int TICK_CYCLES     = 1200000
) (
  input  logic              clk,
  input  logic              rst,
  led_pattern_ctrl_if.slave pins
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_BLINK,
    MODE_CHASE,
    MODE_BINARY
  } mode_t;

  logic [3:0]    sw_raw;
  logic [3:0]    sync_1;
  logic [3:0]    sync_2;
  logic [3:0]    level;
  logic [3:0]    press;
  logic [DW-1:0] db_cnt [4];

  assign sw_raw = {pins.SW4, pins.SW3, pins.SW2, pins.SW1};

  // press[i] fires only when the debounced level rises, so releases are silent
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
      level  <= '0;
      press  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync_1 <= sw_raw;
      sync_2 <= sync_1;
      press  <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync_2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= sync_2[i];
          press[i]  <= sync_2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic          adv_mode;
  logic          toggle_pause;
  logic          next_speed;
  logic          restart;
  logic          clear_cnt;
  logic          clear_step;
  logic          running;
  logic          tick;
  mode_t         mode;
  mode_t         mode_next;
  logic          paused;
  logic [1:0]    speed;
  logic [3:0]    step;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] period_last;
  logic [3:0]    pattern;
  logic [3:0]    leds;
  logic          run_led;

  assign adv_mode     = press[0];
  assign toggle_pause = press[1];
  assign next_speed   = press[2];
  assign restart      = press[3];
  assign clear_cnt    = adv_mode | next_speed | restart;
  assign clear_step   = adv_mode | restart;
  assign running      = (mode != MODE_OFF) && !paused;
  assign period_last  = TW'((TICK_CYCLES >> speed) - 1);
  assign tick         = running && (tick_cnt == period_last);

  always_ff @(posedge clk) begin
    if (rst) mode <= MODE_OFF;
    else     mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    if (adv_mode) begin
      case (mode)
        MODE_OFF:    mode_next = MODE_BLINK;
        MODE_BLINK:  mode_next = MODE_CHASE;
        MODE_CHASE:  mode_next = MODE_BINARY;
        MODE_BINARY: mode_next = MODE_OFF;
        default:     mode_next = MODE_OFF;
      endcase
    end
  end

  always_comb begin
    pattern = 4'b0000;
    case (mode)
      MODE_BLINK:  pattern = {4{step[0]}};
      MODE_CHASE:  pattern = 4'b0001 << step[1:0];
      MODE_BINARY: pattern = step;
      default:     pattern = 4'b0000;
    endcase
  end

  // clears from a command win over a tick landing in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      paused   <= 1'b0;
      speed    <= 2'd0;
      step     <= 4'd0;
      tick_cnt <= '0;
      leds     <= 4'b0000;
      run_led  <= 1'b1;
    end else begin
      if (toggle_pause) paused <= ~paused;
      if (next_speed)   speed  <= speed + 2'd1;

      if (clear_cnt)    tick_cnt <= '0;
      else if (tick)    tick_cnt <= '0;
      else if (running) tick_cnt <= tick_cnt + TW'(1);

      if (clear_step) begin
        step <= 4'd0;
      end else if (tick) begin
        case (mode)
          MODE_BLINK:  step <= {step[3:1], ~step[0]};
          MODE_CHASE:  step <= (step == 4'd3) ? 4'd0 : step + 4'd1;
          MODE_BINARY: step <= step + 4'd1;
          default:     step <= step;
        endcase
      end

      leds    <= pattern;
      run_led <= ~paused;
    end
  end

  assign pins.LED1 = leds[0];
  assign pins.LED2 = leds[1];
  assign pins.LED3 = leds[2];
  assign pins.LED4 = leds[3];
  assign pins.LED5 = run_led;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - scoreboard bench for led_pattern_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=16
module tb_led_pattern_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;

  always #5 clk = ~clk;

  led_pattern_ctrl_if pins();

  assign pins.SW1 = sw[0];
  assign pins.SW2 = sw[1];
  assign pins.SW3 = sw[2];
  assign pins.SW4 = sw[3];

  led_pattern_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pins(pins)
  );

  typedef struct {
    logic [4:0] val;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur_exp;
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  logic [4:0] leds_now;
  logic [4:0] leds_last = 5'bxxxxx;

  always @(posedge clk) cyc <= cyc + 1;

  assign leds_now = {pins.LED5, pins.LED4, pins.LED3, pins.LED2, pins.LED1};

  // every change of {LED5..LED1} must match the next queued value at its predicted cycle
  always @(negedge clk) begin
    if (mon_en && (leds_now !== leds_last)) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change: got %b at cycle %0d, required no change", leds_now, cyc);
      end else begin
        cur_exp = exp_q.pop_front();
        if ((leds_now !== cur_exp.val) || ((cur_exp.cyc >= 0) && (cur_exp.cyc != cyc))) begin
          fails++;
          $display("FAIL led_change: got %b at cycle %0d, required %b at cycle %0d",
                   leds_now, cyc, cur_exp.val, cur_exp.cyc);
        end
      end
      leds_last = leds_now;
    end
  end

  task automatic push(input logic [4:0] v, input int c);
    exp_t x;
    x.val = v;
    x.cyc = c;
    exp_q.push_back(x);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] mask);
    @(posedge clk);
    #1 sw = sw | mask;
    repeat (10) @(posedge clk);
    #1 sw = sw & ~mask;
  endtask

  int e;

  initial begin
    rst = 1'b1;
    sw  = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push(5'b10000, -1);
    mon_en = 1'b1;
    wait_until(cyc + 100);

    // 3-cycle glitch on SW1 must be swallowed
    @(posedge clk);
    #1 sw[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 sw[0] = 1'b0;
    wait_until(cyc + 12);

    // OFF -> BLINK, period 16
    e = cyc + 1;
    push(5'b11111, e + 24);
    push(5'b10000, e + 40);
    press(4'b0001);
    wait_until(e + 40);

    // BLINK -> CHASE, full wrap
    e = cyc + 1;
    push(5'b10001, e + 8);
    push(5'b10010, e + 24);
    push(5'b10100, e + 40);
    push(5'b11000, e + 56);
    push(5'b10001, e + 72);
    press(4'b0001);
    wait_until(e + 72);

    // CHASE -> BINARY, then two speed steps down to period 4
    e = cyc + 1;
    push(5'b10000, e + 8);
    push(5'b10001, e + 24);
    press(4'b0001);
    wait_until(e + 20);

    e = cyc + 1;
    push(5'b10010, e + 16);
    push(5'b10011, e + 24);
    press(4'b0100);
    wait_until(e + 19);

    e = cyc + 1;
    for (int k = 4; k <= 15; k++) push({1'b1, 4'(k)}, e + 8 + 4 * (k - 3));
    push(5'b10000, e + 60);
    push(5'b10001, e + 64);
    press(4'b0100);
    wait_until(e + 57);

    // pause holds value 1 for 60 cycles, resume continues from it
    e = cyc + 1;
    push(5'b00001, e + 8);
    press(4'b0010);
    wait_until(e + 59);

    e = cyc + 1;
    push(5'b10001, e + 8);
    for (int n = 0; n < 8; n++) push({1'b1, 4'(2 + n)}, e + 10 + 4 * n);
    press(4'b0010);
    wait_until(e + 31);

    // restart at value 9
    e = cyc + 1;
    push(5'b10000, e + 8);
    for (int k = 1; k <= 9; k++) push({1'b1, 4'(k)}, e + 8 + 4 * k);
    press(4'b1000);
    wait_until(e + 39);

    // SW1+SW4 together on a tick edge: BINARY -> OFF
    e = cyc + 1;
    push(5'b10000, e + 8);
    press(4'b1001);
    wait_until(e + 40);

    // back to BINARY at period 4, then reset at value 5 with SW2 held
    e = cyc + 1;
    for (int n = 1; n <= 5; n++) push(((n % 2) != 0) ? 5'b11111 : 5'b10000, e + 8 + 4 * n);
    press(4'b0001);
    wait_until(e + 21);

    e = cyc + 1;
    push(5'b10001, e + 8);
    push(5'b10010, e + 12);
    push(5'b10100, e + 16);
    push(5'b11000, e + 20);
    push(5'b10001, e + 24);
    push(5'b10010, e + 28);
    press(4'b0001);
    wait_until(e + 21);

    e = cyc + 1;
    push(5'b10000, e + 8);
    for (int k = 1; k <= 5; k++) push({1'b1, 4'(k)}, e + 8 + 4 * k);
    push(5'b10000, e + 29);
    push(5'b00000, e + 39);
    press(4'b0001);
    wait_until(e + 27);
    sw[1] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_until(cyc + 20);
    sw[1] = 1'b0;
    wait_until(cyc + 30);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_changes: got %0d expected changes never seen, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
